// File: rtl/nzcv_flag_unit.sv
// NZCV flag register with condition evaluation for the issuing instruction
// and a one-entry execute stage tracked through a valid/ready handshake.
module nzcv_flag_unit #(
    parameter int FWD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [3:0] issue_cond,
    input  logic       issue_s,
    input  logic [3:0] alu_nzcv,
    input  logic       psr_we,
    input  logic [3:0] psr_din,
    output logic       flag_c,
    output logic       flag_v,
    output logic [3:0] nzcv_q,
    output logic       ex_valid,
    output logic       ex_pass
);

    logic       ex_s;
    logic       ex_commit;
    logic       commit_pending;
    logic       issue_fire;
    logic [3:0] eval_flags;

    // Conditions come in pairs; the odd member of each pair is the inverse.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        return cond[0] ? ~r : r;
    endfunction

    assign ex_commit      = ex_valid && ex_s && ex_pass;
    assign commit_pending = ex_commit && !psr_we;
    assign issue_fire     = issue_valid && issue_ready;

    always_comb begin
        eval_flags  = nzcv_q;
        issue_ready = 1'b1;
        if (FWD != 0) begin
            if (psr_we)
                eval_flags = psr_din;
            else if (commit_pending)
                eval_flags = alu_nzcv;
        end else begin
            // Without forwarding, hold issue until the in-flight flag update lands.
            issue_ready = !ex_commit && !psr_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_s     <= 1'b0;
            ex_pass  <= 1'b0;
        end else if (issue_fire) begin
            ex_valid <= 1'b1;
            ex_s     <= issue_s;
            ex_pass  <= cond_eval(issue_cond, eval_flags);
        end else begin
            ex_valid <= 1'b0;
            ex_s     <= 1'b0;
            ex_pass  <= 1'b0;
        end
    end

    // A direct write overrides, and drops, a concurrent ALU commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            nzcv_q <= 4'b0000;
        else if (psr_we)
            nzcv_q <= psr_din;
        else if (ex_commit)
            nzcv_q <= alu_nzcv;
    end

    assign flag_c = nzcv_q[1];
    assign flag_v = nzcv_q[0];

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed bench for nzcv_flag_unit: one forwarding instance and one
// stalling instance, each driven by its own inputs.
module tb_nzcv_flag_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // forwarding instance (FWD=1)
    logic       f_valid, f_ready, f_s, f_we, f_c, f_v, f_exv, f_pass;
    logic [3:0] f_cond, f_alu, f_din, f_q;
    // stalling instance (FWD=0)
    logic       s_valid, s_ready, s_s, s_we, s_c, s_v, s_exv, s_pass;
    logic [3:0] s_cond, s_alu, s_din, s_q;

    int tests = 0;
    int failed = 0;

    nzcv_flag_unit #(.FWD(1)) dut_fwd (
        .clk(clk), .rst(rst), .issue_valid(f_valid), .issue_ready(f_ready),
        .issue_cond(f_cond), .issue_s(f_s), .alu_nzcv(f_alu), .psr_we(f_we),
        .psr_din(f_din), .flag_c(f_c), .flag_v(f_v), .nzcv_q(f_q),
        .ex_valid(f_exv), .ex_pass(f_pass)
    );

    nzcv_flag_unit #(.FWD(0)) dut_stall (
        .clk(clk), .rst(rst), .issue_valid(s_valid), .issue_ready(s_ready),
        .issue_cond(s_cond), .issue_s(s_s), .alu_nzcv(s_alu), .psr_we(s_we),
        .psr_din(s_din), .flag_c(s_c), .flag_v(s_v), .nzcv_q(s_q),
        .ex_valid(s_exv), .ex_pass(s_pass)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference condition table, written out one condition at a time.
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic fwd_issue(input logic [3:0] cond, input logic s);
        f_valid = 1'b1;
        f_cond  = cond;
        f_s     = s;
        step();
        f_valid = 1'b0;
        f_s     = 1'b0;
    endtask

    task automatic fwd_write(input logic [3:0] v);
        f_we  = 1'b1;
        f_din = v;
        step();
        f_we  = 1'b0;
    endtask

    initial begin
        f_valid = 0; f_s = 0; f_we = 0; f_cond = 0; f_alu = 0; f_din = 0;
        s_valid = 0; s_s = 0; s_we = 0; s_cond = 0; s_alu = 0; s_din = 0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_nzcv", f_q, 4'h0);
        chk("rst_exv", {3'b0, f_exv}, 4'h0);
        chk("rst_ready", {3'b0, f_ready}, 4'h1);
        chk("rst_c", {3'b0, f_c}, 4'h0);
        chk("rst_v", {3'b0, f_v}, 4'h0);
        chk("rst_ready_stall", {3'b0, s_ready}, 4'h1);

        // reset while a flag-setting instruction sits in EX
        fwd_issue(4'hE, 1'b1);
        chk("midex_exv", {3'b0, f_exv}, 4'h1);
        f_alu = 4'hF;
        rst = 1'b1;
        #1;
        chk("midex_async_exv", {3'b0, f_exv}, 4'h0);
        step();
        rst = 1'b0;
        step();
        chk("midex_nzcv", f_q, 4'h0);
        chk("midex_exv2", {3'b0, f_exv}, 4'h0);
        chk("midex_ready", {3'b0, f_ready}, 4'h1);
        chk("midex_c", {3'b0, f_c}, 4'h0);

        // forwarding: S=1 AL then dependent EQ next cycle
        f_alu = 4'h0;
        fwd_issue(4'hE, 1'b1);
        f_alu   = 4'b0100;
        f_valid = 1'b1;
        f_cond  = 4'h0;
        #1;
        chk("fwd_ready", {3'b0, f_ready}, 4'h1);
        step();
        f_valid = 1'b0;
        chk("fwd_eq_pass", {3'b0, f_pass}, 4'h1);
        chk("fwd_eq_exv", {3'b0, f_exv}, 4'h1);
        chk("fwd_nzcv", f_q, 4'b0100);

        // stall: same sequence on the FWD=0 instance
        s_valid = 1'b1; s_cond = 4'hE; s_s = 1'b1;
        #1;
        chk("stall_ready0", {3'b0, s_ready}, 4'h1);
        step();
        s_s = 1'b0; s_cond = 4'h0; s_alu = 4'b0100;
        #1;
        chk("stall_bubble", {3'b0, s_ready}, 4'h0);
        step();
        chk("stall_nzcv", s_q, 4'b0100);
        chk("stall_noissue", {3'b0, s_exv}, 4'h0);
        chk("stall_ready1", {3'b0, s_ready}, 4'h1);
        step();
        s_valid = 1'b0;
        chk("stall_eq_exv", {3'b0, s_exv}, 4'h1);
        chk("stall_eq_pass", {3'b0, s_pass}, 4'h1);

        // full sweep, no flag-setting instructions in flight
        f_alu = 4'hF;
        for (int f = 0; f < 16; f++) begin
            fwd_write(4'(f));
            for (int c = 0; c < 16; c++) begin
                fwd_issue(4'(c), 1'b0);
                chk($sformatf("sweep_c%0h_f%0h", c, f), {3'b0, f_pass},
                    {3'b0, ref_cond(4'(c), 4'(f))});
            end
            chk($sformatf("sweep_hold_f%0h", f), f_q, 4'(f));
        end

        // spot checks
        fwd_write(4'b1001);
        fwd_issue(4'hC, 1'b0);
        chk("gt_1001", {3'b0, f_pass}, 4'h1);
        fwd_write(4'b1000);
        fwd_issue(4'hA, 1'b0);
        chk("ge_1000", {3'b0, f_pass}, 4'h0);
        fwd_issue(4'hF, 1'b0);
        chk("nv_1000", {3'b0, f_pass}, 4'h0);

        // failed S instruction does not commit
        fwd_write(4'b0100);
        fwd_issue(4'h1, 1'b1);
        f_alu = 4'b1010;
        chk("failS_pass", {3'b0, f_pass}, 4'h0);
        step();
        chk("failS_nzcv", f_q, 4'b0100);

        // direct write beats pending ALU commit
        f_alu = 4'b0000;
        fwd_issue(4'hE, 1'b1);
        f_alu = 4'b1100;
        fwd_write(4'b0011);
        chk("prio_nzcv", f_q, 4'b0011);
        chk("prio_c", {3'b0, f_c}, 4'h1);
        chk("prio_v", {3'b0, f_v}, 4'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
